alu_op_sequencer: RTL and testbench

//  Sequences one ALU operation at a time through alu_unit_interface:

---
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
//==============================================================================
// Module      : alu_op_sequencer
// Description : Issues one command at a time to the ALU interface. It steps
//               control_state through the decode, operand-load and execute
//               phases, then returns the ALU result on a valid/ready response.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int ALU_WIDTH      = 8,
  parameter int ALU_OPS        = 16,
  parameter int A_REG_MAP      = 16,
  parameter int B_REG_MAP      = 17,
  parameter int CONTROL_STATES = 3,
  parameter int DECODE         = 0,
  parameter int EXECUTE1       = 1,
  parameter int EXECUTE2       = 2
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(ALU_OPS)-1:0]    cmd_op,
  input  logic [ALU_WIDTH-1:0]          cmd_a,
  input  logic [ALU_WIDTH-1:0]          cmd_b,
  output logic [$clog2(CONTROL_STATES)-1:0] control_state,
  output logic                          alu_en,
  output logic [$clog2(ALU_OPS)-1:0]    alu_op,
  output logic [4:0]                    reg_src,
  output logic [ALU_WIDTH-1:0]          A_bus,
  output logic [ALU_WIDTH-1:0]          B_bus,
  input  logic [ALU_WIDTH-1:0]          alu_result,
  input  logic                          cc_greater,
  input  logic                          cc_equal,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ALU_WIDTH-1:0]          rsp_result,
  output logic                          rsp_greater,
  output logic                          rsp_equal,
  output logic                          rsp_err
);

  localparam int OP_W = $clog2(ALU_OPS);
  localparam int CS_W = $clog2(CONTROL_STATES);

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(9);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_CAPT   = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_accept;
  logic       w_illegal;
  logic       w_unary;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_illegal = (cmd_op > OP_LAST);
  assign w_unary   = (alu_op == OP_NOP) || (alu_op == OP_NOT);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_illegal ? S_RESP : S_DECODE;
      S_DECODE: w_next = S_LOAD_A;
      S_LOAD_A: w_next = w_unary ? S_EXEC : S_LOAD_B;
      S_LOAD_B: w_next = S_EXEC;
      S_EXEC:   w_next = S_CAPT;
      S_CAPT:   w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // ALU-side controls decode straight from the state flop so reset clears them at once.
  always_comb begin
    control_state = CS_W'(DECODE);
    alu_en        = 1'b0;
    reg_src       = 5'd0;
    case (r_state)
      S_LOAD_A: begin
        control_state = CS_W'(EXECUTE1);
        alu_en        = 1'b1;
        reg_src       = 5'(A_REG_MAP);
      end
      S_LOAD_B: begin
        control_state = CS_W'(EXECUTE1);
        alu_en        = 1'b1;
        reg_src       = 5'(B_REG_MAP);
      end
      S_EXEC: begin
        control_state = CS_W'(EXECUTE2);
        alu_en        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0;
      A_bus  <= '0;
      B_bus  <= '0;
    end else if (w_accept) begin
      alu_op <= cmd_op;
      A_bus  <= cmd_a;
      B_bus  <= cmd_b;
    end
  end

  // Illegal opcodes bypass the ALU and answer straight from IDLE with zeroed data.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_greater <= 1'b0;
      rsp_equal   <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_illegal) begin
            rsp_valid   <= 1'b1;
            rsp_result  <= '0;
            rsp_greater <= 1'b0;
            rsp_equal   <= 1'b0;
            rsp_err     <= 1'b1;
          end
        end
        S_CAPT: begin
          rsp_valid   <= 1'b1;
          rsp_result  <= alu_result;
          rsp_greater <= cc_greater;
          rsp_equal   <= cc_equal;
          rsp_err     <= 1'b0;
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
//==============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed vector bench for alu_op_sequencer with a small
//               registered ALU model on the interface side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic       sysclk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [1:0] control_state;
  logic       alu_en;
  logic [3:0] alu_op;
  logic [4:0] reg_src;
  logic [7:0] A_bus;
  logic [7:0] B_bus;
  logic [7:0] alu_result;
  logic       cc_greater;
  logic       cc_equal;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_greater;
  logic       rsp_equal;
  logic       rsp_err;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .control_state(control_state), .alu_en(alu_en), .alu_op(alu_op),
    .reg_src(reg_src), .A_bus(A_bus), .B_bus(B_bus),
    .alu_result(alu_result), .cc_greater(cc_greater), .cc_equal(cc_equal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_greater(rsp_greater), .rsp_equal(rsp_equal), .rsp_err(rsp_err)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // ALU interface model: operand registers are never reset.
  logic [7:0] m_a;
  logic [7:0] m_b;
  always @(posedge sysclk) begin
    logic [7:0] t;
    if (alu_en && control_state == 2'd1 && reg_src == 5'd16) m_a <= A_bus;
    if (alu_en && control_state == 2'd1 && reg_src == 5'd17) m_b <= B_bus;
    if (alu_en && control_state == 2'd2) begin
      case (alu_op)
        4'd1: t = m_a + m_b;
        4'd2: t = m_a - m_b;
        4'd3: t = m_a | m_b;
        4'd4: t = m_a & m_b;
        4'd5: t = ~m_a;
        4'd6: t = m_a << m_b[2:0];
        4'd7: t = m_a >> m_b[2:0];
        4'd8: t = 8'($signed(m_a) >>> m_b[2:0]);
        default: t = 8'h00;
      endcase
      alu_result <= t;
      cc_greater <= (alu_op == 4'd9) && (m_a > m_b);
      cc_equal   <= (alu_op == 4'd9) && (m_a == m_b);
    end
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       g;
    logic       e;
    logic       err;
    int         lat;
    int         na;
    int         nb;
    int         ne;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Present a command and return #1 after the edge that accepts it.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic ok);
    @(negedge sysclk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge sysclk);
    end
    if (ok) begin
      @(posedge sysclk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int na, output int nb, output int ne,
                          output int nen);
    logic got;
    got = 1'b0; lat = 0; na = 0; nb = 0; ne = 0; nen = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge sysclk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
      end else begin
        if (alu_en) nen++;
        if (alu_en && control_state == 2'd1 && reg_src == 5'd16) na++;
        if (alu_en && control_state == 2'd1 && reg_src == 5'd17) nb++;
        if (alu_en && control_state == 2'd2) ne++;
      end
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge sysclk);
    #1 rsp_ready = 1'b0;
    @(negedge sysclk);
    chk({tag, "_rsp_valid_drop"}, rsp_valid, 1'b0);
    chk({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
  endtask

  task automatic run(input vec_t v, input string tag);
    logic ok;
    int lat, na, nb, ne, nen;
    issue(v.op, v.a, v.b, ok);
    chk({tag, "_accept"}, ok, 1'b1);
    if (!ok) return;
    wait_rsp(lat, na, nb, ne, nen);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_result"}, rsp_result, v.res);
    chk({tag, "_greater"}, rsp_greater, v.g);
    chk({tag, "_equal"}, rsp_equal, v.e);
    chk({tag, "_err"}, rsp_err, v.err);
    chk({tag, "_a_loads"}, na, v.na);
    chk({tag, "_b_loads"}, nb, v.nb);
    chk({tag, "_exec"}, ne, v.ne);
    chk({tag, "_en_cycles"}, nen, v.na + v.nb + v.ne);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic stable;
    int lat, na, nb, ne, nen;

    //        op     a      b      res    g  e  err lat na nb ne
    vecs[0]  = '{4'h1, 8'h3C, 8'h05, 8'h41, 0, 0, 0, 6, 1, 1, 1};
    vecs[1]  = '{4'h5, 8'hA5, 8'h00, 8'h5A, 0, 0, 0, 5, 1, 0, 1};
    vecs[2]  = '{4'h9, 8'h80, 8'h7F, 8'h00, 1, 0, 0, 6, 1, 1, 1};
    vecs[3]  = '{4'hC, 8'h12, 8'h34, 8'h00, 0, 0, 1, 1, 0, 0, 0};
    vecs[4]  = '{4'h9, 8'h22, 8'h22, 8'h00, 0, 1, 0, 6, 1, 1, 1};
    vecs[5]  = '{4'h2, 8'h05, 8'h07, 8'hFE, 0, 0, 0, 6, 1, 1, 1};
    vecs[6]  = '{4'h3, 8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 6, 1, 1, 1};
    vecs[7]  = '{4'h4, 8'h3C, 8'h0F, 8'h0C, 0, 0, 0, 6, 1, 1, 1};
    vecs[8]  = '{4'h6, 8'h81, 8'h01, 8'h02, 0, 0, 0, 6, 1, 1, 1};
    vecs[9]  = '{4'h7, 8'h81, 8'h03, 8'h10, 0, 0, 0, 6, 1, 1, 1};
    vecs[10] = '{4'h8, 8'h81, 8'h01, 8'hC0, 0, 0, 0, 6, 1, 1, 1};
    vecs[11] = '{4'h0, 8'h55, 8'hAA, 8'h00, 0, 0, 0, 5, 1, 0, 1};
    vecs[12] = '{4'hF, 8'hFF, 8'hFF, 8'h00, 0, 0, 1, 1, 0, 0, 0};
    vecs[13] = '{4'h9, 8'h10, 8'h20, 8'h00, 0, 0, 0, 6, 1, 1, 1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_control_state", control_state, 2'd0);
    chk("rst_alu_en", alu_en, 1'b0);
    chk("rst_reg_src", reg_src, 5'd0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_buses", {A_bus, B_bus}, 16'h0);
    chk("rst_rsp", {rsp_valid, rsp_result, rsp_greater, rsp_equal, rsp_err}, 12'h0);
    rst_n = 1'b1;

    // rsp_ready while idle must be harmless
    rsp_ready = 1'b1;
    repeat (2) @(negedge sysclk);
    rsp_ready = 1'b0;
    chk("idle_rsp_ready_no_effect", {rsp_valid, cmd_ready}, 2'b01);

    for (int i = 0; i < 14; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held, second command ignored until handshake.
    issue(4'h1, 8'h3C, 8'h05, ok);
    chk("bp_accept", ok, 1'b1);
    wait_rsp(lat, na, nb, ne, nen);
    chk("bp_latency", lat, 6);
    cmd_valid = 1'b1; cmd_op = 4'h2; cmd_a = 8'h11; cmd_b = 8'h22;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge sysclk);
      if (!(rsp_valid && rsp_result == 8'h41 && !rsp_err && !rsp_greater && !rsp_equal &&
            !cmd_ready && alu_op == 4'h1 && A_bus == 8'h3C && !alu_en))
        stable = 1'b0;
    end
    chk("bp_hold_stable", stable, 1'b1);
    rsp_ready = 1'b1;
    @(posedge sysclk);
    #1 rsp_ready = 1'b0;
    @(negedge sysclk);
    chk("bp_release_ready", {cmd_ready, rsp_valid}, 2'b10);
    @(posedge sysclk);
    #1 cmd_valid = 1'b0;
    chk("bp_next_latched", {alu_op, A_bus, B_bus}, {4'h2, 8'h11, 8'h22});
    wait_rsp(lat, na, nb, ne, nen);
    chk("bp_next_latency", lat, 6);
    chk("bp_next_result", rsp_result, 8'hEF);
    handshake("bp_next");

    // Reset during LOAD_B aborts the command.
    issue(4'h2, 8'h05, 8'h07, ok);
    chk("rstmid_accept", ok, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge sysclk);
      if (reg_src == 5'd17) ok = 1'b1;
    end
    chk("rstmid_reach_load_b", ok, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs", control_state, 2'd0);
    chk("rstmid_alu_en", alu_en, 1'b0);
    chk("rstmid_rsp_valid", rsp_valid, 1'b0);
    chk("rstmid_reg_src", reg_src, 5'd0);
    chk("rstmid_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = 4'h3; cmd_a = 8'h99; cmd_b = 8'h66;
    repeat (2) @(negedge sysclk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rstmid_no_accept", {cmd_ready, alu_op, A_bus}, {1'b1, 4'h0, 8'h00});
    run('{4'h2, 8'h05, 8'h07, 8'hFE, 0, 0, 0, 6, 1, 1, 1}, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
